mips_cpu_bus_mem_if: RTL and testbench
======================================

Name: mips_cpu_bus_mem_if

Overview:
Load/store bus master between the CPU datapath and the Avalon-style data memory bus.
- Accepts one load or store request at a time from the core.
- Checks alignment, forms the word-aligned bus address, byteenable and lane-shifted writedata.
- Holds the request until waitrequest drops, then waits a fixed read latency.
- Returns zero- or sign-extended load data with a one-cycle response strobe.

Parameters:
READ_LATENCY, 1, posedge clock edges from read acceptance to the edge at which readdata is valid and sampled (1..4).

Ports:
clk  in  1  system clock; all state on posedge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  core request strobe; sampled only while req_ready=1.
req_ready  out  1  block idle and able to accept a request.
req_write  in  1  1=store, 0=load.
req_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle pulse: load data valid or store complete.
resp_rdata  out  32  extended load data; 0 after stores.
resp_misaligned  out  1  one-cycle pulse: request rejected; no bus access.
address  out  32  bus byte address, always {req_addr[31:2],2'b00}.
read  out  1  bus read request.
write  out  1  bus write request.
byteenable  out  4  active byte lanes.
writedata  out  32  lane-aligned store data.
waitrequest  in  1  slave stall; request is accepted at a posedge with waitrequest=0.
readdata  in  32  bus read data.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - req_ready=1; read=0; write=0; byteenable=0; address=0; writedata=0.
  - resp_valid=0; resp_rdata=0; resp_misaligned=0; latency counter=0.
- FSM states: IDLE, BUS, RWAIT, RESP.
- IDLE: req_ready=1. On posedge with req_valid=1, latch addr/size/signed/write/wdata.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): pulse resp_misaligned next cycle; stay IDLE.
  - Aligned request: go to BUS.
- BUS: req_ready=0.
  - read=~wr and write=wr, both registered; exactly one is high, never both.
  - address, byteenable and writedata are held stable until acceptance.
  - Acceptance is a posedge with waitrequest=0.
    - Store: go to RESP.
    - Load: clear read; load counter with READ_LATENCY-1; go to RWAIT.
  - waitrequest=1 at an edge: stay in BUS with all outputs unchanged; unbounded stall allowed.
- RWAIT: counter decrements each edge.
  - At the edge where the counter is 0, sample readdata.
  - Extract the lane selected by the latched addr[1:0] and extend it.
  - Register the result into resp_rdata; go to RESP.
  - With READ_LATENCY=1 this is the first edge after acceptance.
- RESP: resp_valid=1 for exactly one cycle.
  - resp_rdata is held until the next response; it is set to 0 on store completion.
  - Return to IDLE; req_ready=1 from the following cycle.
- Lane rules, where o = addr[1:0]:
  - Byte: byteenable=1<<o; writedata = wdata[7:0] replicated on all 4 lanes.
  - Half: byteenable=0011 (o=0) or 1100 (o=2); writedata = wdata[15:0] replicated on both halves.
  - Word: byteenable=1111; writedata=wdata.
  - Load extraction: byte = readdata[8o+7:8o]; half = readdata[8o+15:8o]. Sign bit is the MSB of the extracted field.
- Throughput:
  - Load: 1 IDLE + 1 BUS + READ_LATENCY + 1 RESP cycles, minimum 4.
  - Store: minimum 3 cycles.
- req_valid outside IDLE is ignored; there is no queueing.
- reset_n asserted mid-transaction: read and write drop immediately (async); the pending response is discarded.

Test Plan:
- Store word: addr=0x1004, wdata=0xDEADBEEF, waitrequest=0 → one bus cycle with address=0x1004, byteenable=1111, writedata=0xDEADBEEF, write=1; resp_valid pulses 1 cycle later, resp_rdata=0.
- Store byte: addr=0x1007, wdata=0x000000A5 → address=0x1004, byteenable=1000, writedata=0xA5A5A5A5.
- Load byte: addr=0x1006, readdata=0x80FF7F01; signed → resp_rdata=0xFFFFFFFF; unsigned → 0x000000FF.
- Load half signed: addr=0x1002, readdata=0x8001xxxx → byteenable=1100, resp_rdata=0xFFFF8001; half at addr=0x1000 with readdata[15:0]=0x7FFE → 0x00007FFE.
- waitrequest=1 for 3 edges on a load → read, address and byteenable stable for 4 cycles; resp_valid arrives 3 cycles later than the no-stall case; with READ_LATENCY=3 → one pulse, 2 further cycles later.
- Misaligned word at addr=0x1002 → resp_misaligned pulse, read=write=0 throughout, req_ready remains 1. reset_n low during BUS → read=0 immediately, no resp_valid after release.

Source files
------------

// File: rtl/mips_cpu_bus_mem_if_if.sv
// Signal bundle between the load/store unit, the core request port and the data memory bus.
// The master modport is the load/store unit; the slave modport is the core plus memory environment.
interface mips_cpu_bus_mem_if_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output address, read, write, byteenable, writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  address, read, write, byteenable, writedata
  );
endinterface

// File: rtl/mips_cpu_bus_mem_if.sv
// Single-outstanding load/store bus master: alignment check, lane steering, fixed-latency
// read capture and load-data extension.
module mips_cpu_bus_mem_if #(
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                         clk,
  input logic                         reset_n,
  mips_cpu_bus_mem_if_if.master       bus
);

  typedef enum logic [1:0] {StIdle, StBus, StRwait, StResp} state_e;

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mis_q, mis_d;

  logic        req_misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] rd_lane;
  logic [31:0] load_ext;

  // Request-side decode: size 2'b11 falls through to word handling.
  always_comb begin
    req_misaligned = 1'b0;
    lane_be        = 4'b1111;
    lane_wd        = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        lane_be = 4'b0001 << bus.req_addr[1:0];
        lane_wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = bus.req_addr[0];
        lane_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wd        = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        req_misaligned = (bus.req_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Load-side extraction uses the offset latched at request time.
  always_comb begin
    rd_lane  = bus.readdata >> {off_q, 3'b000};
    load_ext = bus.readdata;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_lane[7]}}, rd_lane[7:0]};
      2'b01:   load_ext = {{16{signed_q & rd_lane[15]}}, rd_lane[15:0]};
      default: load_ext = bus.readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    be_d         = be_q;
    wd_d         = wd_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = 1'b0;
    mis_d        = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_misaligned) begin
            mis_d = 1'b1;
          end else begin
            state_d   = StBus;
            read_d    = ~bus.req_write;
            write_d   = bus.req_write;
            address_d = {bus.req_addr[31:2], 2'b00};
            be_d      = lane_be;
            wd_d      = lane_wd;
            off_d     = bus.req_addr[1:0];
            size_d    = bus.req_size;
            signed_d  = bus.req_signed;
          end
        end
      end
      StBus: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = StRwait;
            cnt_d   = 2'(READ_LATENCY - 1);
          end
        end
      end
      StRwait: begin
        if (cnt_q == 2'd0) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      be_q         <= '0;
      wd_q         <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      be_q         <= be_d;
      wd_q         <= wd_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mis_q        <= mis_d;
    end
  end

  assign bus.req_ready       = (state_q == StIdle);
  assign bus.read            = read_q;
  assign bus.write           = write_q;
  assign bus.address         = address_q;
  assign bus.byteenable      = be_q;
  assign bus.writedata       = wd_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = mis_q;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(read_q && write_q));

  a_bus_hold: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == StBus && bus.waitrequest) |=>
      (state_q == StBus && $stable(address_q) && $stable(be_q) && $stable(wd_q) &&
       $stable(read_q) && $stable(write_q)));

endmodule

// File: tb/tb_mips_cpu_bus_mem_if.sv
// Randomized bench: a per-cycle transaction timeline and lane/extension model drive the
// expectations, and one negedge process compares every DUT output against them.
module tb_mips_cpu_bus_mem_if;
  localparam int unsigned RL = 3;

  logic clk = 1'b0;
  logic reset_n;

  mips_cpu_bus_mem_if_if bus_if ();

  mips_cpu_bus_mem_if #(.READ_LATENCY(RL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        chk_en  = 1'b0;
  logic        chk_bus = 1'b0;
  logic        e_ready, e_read, e_write, e_rv, e_mis;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0]  e_be;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready", 32'(bus_if.req_ready), 32'(e_ready));
      cmp("read", 32'(bus_if.read), 32'(e_read));
      cmp("write", 32'(bus_if.write), 32'(e_write));
      cmp("resp_valid", 32'(bus_if.resp_valid), 32'(e_rv));
      cmp("resp_misaligned", 32'(bus_if.resp_misaligned), 32'(e_mis));
      cmp("resp_rdata", bus_if.resp_rdata, e_rdata);
      if (chk_bus) begin
        cmp("address", bus_if.address, e_addr);
        cmp("byteenable", 32'(bus_if.byteenable), 32'(e_be));
        if (e_write) cmp("writedata", bus_if.writedata, e_wd);
      end
    end
  end

  // Reference model: plain arithmetic on the request fields.
  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return a[0];
    return a[1:0] != 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
    int unsigned o = 32'(a[1:0]);
    if (size == 2'd0) return 4'(1 << o);
    if (size == 2'd1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return 32'(w[7:0]) * 32'h0101_0101;
    if (size == 2'd1) return 32'(w[15:0]) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] size, input logic sgn,
                                       input logic [31:0] a, input logic [31:0] rd);
    int unsigned o = 32'(a[1:0]);
    logic [31:0] v = rd >> (8 * o);
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    bus_if.req_valid   = 1'($urandom);
    bus_if.req_write   = 1'($urandom);
    bus_if.req_size    = 2'($urandom);
    bus_if.req_signed  = 1'($urandom);
    bus_if.req_addr    = $urandom;
    bus_if.req_wdata   = $urandom;
    bus_if.waitrequest = 1'($urandom);
    bus_if.readdata    = $urandom;
  endtask

  task automatic set_exp(input logic rdy, input logic rd, input logic wr, input logic rv,
                         input logic mis, input logic bchk);
    e_ready = rdy;
    e_read  = rd;
    e_write = wr;
    e_rv    = rv;
    e_mis   = mis;
    chk_bus = bchk;
  endtask

  task automatic idle_cycle();
    junk();
    bus_if.req_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
  endtask

  // Walks one transaction cycle by cycle; entered and left in an idle cycle at posedge+1.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdword, input int stalls, input logic [3:0] xbe,
                         input logic [31:0] xwd, input logic [31:0] xrd, input logic xmis);
    junk();
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = wr;
    bus_if.req_size   = size;
    bus_if.req_signed = sgn;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    if (xmis) begin
      junk();
      bus_if.req_valid = 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_cycle();
      return;
    end
    e_addr = {addr[31:2], 2'b00};
    e_be   = xbe;
    e_wd   = xwd;
    for (int s = 0; s <= stalls; s++) begin
      junk();
      bus_if.waitrequest = (s < stalls);
      set_exp(1'b0, ~wr, wr, 1'b0, 1'b0, 1'b1);
      next_cycle();
    end
    if (!wr) begin
      for (int k = 0; k < int'(RL); k++) begin
        junk();
        if (k == int'(RL) - 1) bus_if.readdata = rdword;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
      end
    end
    junk();
    e_rdata = wr ? 32'h0 : xrd;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        wr, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdw;
    int          stalls;

    reset_n = 1'b0;
    junk();
    bus_if.req_valid = 1'b0;
    e_rdata = 32'h0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    cmp("rst_req_ready", 32'(bus_if.req_ready), 32'h1);
    cmp("rst_read", 32'(bus_if.read), 32'h0);
    cmp("rst_write", 32'(bus_if.write), 32'h0);
    cmp("rst_byteenable", 32'(bus_if.byteenable), 32'h0);
    cmp("rst_address", bus_if.address, 32'h0);
    cmp("rst_writedata", bus_if.writedata, 32'h0);
    cmp("rst_resp_valid", 32'(bus_if.resp_valid), 32'h0);
    cmp("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    cmp("rst_resp_misaligned", 32'(bus_if.resp_misaligned), 32'h0);
    next_cycle();
    reset_n = 1'b1;
    idle_cycle();
    chk_en = 1'b1;
    idle_cycle();

    // Directed cases with hand-computed expectations.
    run_txn(1'b0, 2'd0, 1'b1, 32'h1006, 32'h0, 32'h80FF7F01, 0, 4'b0100, 32'h0, 32'hFFFFFFFF, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h1006, 32'h0, 32'h80FF7F01, 0, 4'b0100, 32'h0, 32'h000000FF, 1'b0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h80011234, 0, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 32'h12347FFE, 0, 4'b0011, 32'h0, 32'h00007FFE, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 32'hCAFEF00D, 3, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
    run_txn(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    run_txn(1'b1, 2'd0, 1'b0, 32'h1007, 32'h000000A5, 32'h0, 2, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);
    run_txn(1'b1, 2'd3, 1'b0, 32'h1002, 32'h11223344, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
    run_txn(1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
    idle_cycle();

    for (int n = 0; n < 300; n++) begin
      wr     = 1'($urandom);
      size   = 2'($urandom);
      sgn    = 1'($urandom);
      addr   = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      wdata  = $urandom;
      rdw    = $urandom;
      stalls = int'($urandom_range(0, 3));
      run_txn(wr, size, sgn, addr, wdata, rdw, stalls, m_be(size, addr), m_wd(size, wdata),
              m_rd(size, sgn, addr, rdw), m_mis(size, addr));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Reset asserted while a load is stalled on the bus.
    junk();
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = 1'b0;
    bus_if.req_size   = 2'd2;
    bus_if.req_addr   = 32'h3000;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    bus_if.req_valid   = 1'b0;
    bus_if.waitrequest = 1'b1;
    e_addr = 32'h3000;
    e_be   = 4'hF;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    cmp("async_rst_read", 32'(bus_if.read), 32'h0);
    cmp("async_rst_ready", 32'(bus_if.req_ready), 32'h1);
    next_cycle();
    bus_if.waitrequest = 1'b0;
    bus_if.readdata    = 32'h5555AAAA;
    reset_n = 1'b1;
    e_rdata = 32'h0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    repeat (RL + 4) idle_cycle();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
